// File: rtl/calc_pkg.sv
// calc_pkg: shared types and limits for the keypad calculator sequencer.
//   - calcState_t : FSM state encoding (ENTRY, SHOW, ERROR)
//   - OPERAND_W / ACC_W : datapath widths
//   - MAX_DIGITS / MAX_ACC : entry and accumulator limits
//   - Key bit positions inside the packed 14-bit key vector
package calc_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        SHOW  = 2'd1,
        ERROR = 2'd2
    } calcState_t;

    localparam int OPERAND_W  = 14;
    localparam int ACC_W      = 17;
    localparam int SUM_W      = ACC_W + 1;
    localparam int CNT_W      = 3;
    localparam int MAX_DIGITS = 4;
    localparam int MAX_ACC    = 99999;

    // Packed key vector layout: digits in [9:0], command keys above.
    localparam int NUM_KEYS   = 14;
    localparam int KEY_ENTER  = 10;
    localparam int KEY_NUMBER = 11;
    localparam int KEY_TOTAL  = 12;
    localparam int KEY_CLEAR  = 13;

endpackage

// File: rtl/calc_key_edge.sv
// calc_key_edge: per-bit rising-edge detector for raw key levels.
//   Optional 2-flop synchronizer when CALC_SYNC_EN is defined.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   keys[W]    : raw key levels
//   level[W]   : sampled (post-synchronizer) key levels
//   rise[W]    : one-cycle event per press
module calc_key_edge #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] keys,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] sampled;
    logic [W-1:0] prev;
    logic [W-1:0] armed;

`ifdef CALC_SYNC_EN
    logic [W-1:0] sync1;
    logic [W-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    assign sampled = sync2;
`else
    assign sampled = keys;
`endif

    // armed goes high once a bit has been sampled low, so a key held
    // through reset release cannot fire until it is released and re-pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= '0;
            armed <= '0;
        end else begin
            prev  <= sampled;
            armed <= armed | ~sampled;
        end
    end

    assign level = sampled;
    assign rise  = sampled & ~prev & armed;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: key event decode, operand builder, accumulator and
// display select for the keypad calculator, in one clocked FSM.
// Optional feature macro: CALC_SYNC_EN (2-flop key synchronizers,
// latency 3 cycles instead of 1).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   key_enter     : add operand to accumulator
//   key_number    : back to operand entry
//   key_total     : show accumulator
//   key_clear     : clear everything
//   digit_keys    : one-hot digit keys 0..9
//   operand       : operand being entered (0..9999)
//   acc           : running sum (0..99999)
//   disp_value    : value to BCD converter
//   show / err    : state decode of SHOW / ERROR
//   digit_cnt     : digits entered (0..4)
module calc_sequencer
    import calc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_enter,
    input  logic                 key_number,
    input  logic                 key_total,
    input  logic                 key_clear,
    input  logic [9:0]           digit_keys,
    output logic [OPERAND_W-1:0] operand,
    output logic [ACC_W-1:0]     acc,
    output logic [ACC_W-1:0]     disp_value,
    output logic                 show,
    output logic                 err,
    output logic [CNT_W-1:0]     digit_cnt
);

    logic [NUM_KEYS-1:0] keyLevel;
    logic [NUM_KEYS-1:0] keyRise;

    calc_key_edge #(.W(NUM_KEYS)) uKeyEdge (
        .clk   (clk),
        .rst   (rst),
        .keys  ({key_clear, key_total, key_number, key_enter, digit_keys}),
        .level (keyLevel),
        .rise  (keyRise)
    );

    calcState_t state;

    logic [9:0] digitRise;
    logic [9:0] digitLevel;
    logic       digitValid;
    logic [3:0] digitIdx;

    assign digitRise  = keyRise[9:0];
    assign digitLevel = keyLevel[9:0];

    // Valid only when one digit rises and no other digit is held.
    assign digitValid = (digitRise != '0) &&
                        ((digitRise & (digitRise - 10'd1)) == '0) &&
                        (digitLevel == digitRise);

    always_comb begin
        digitIdx = '0;
        for (int i = 0; i < 10; i++) begin
            if (digitRise[i]) digitIdx = 4'(i);
        end
    end

    logic [SUM_W-1:0]     sum;
    logic [OPERAND_W-1:0] shifted;

    assign sum     = {1'b0, acc} + SUM_W'(operand);
    assign shifted = OPERAND_W'(operand * OPERAND_W'(10)) + OPERAND_W'(digitIdx);

    calcState_t           nState;
    logic [OPERAND_W-1:0] nOperand;
    logic [ACC_W-1:0]     nAcc;
    logic [CNT_W-1:0]     nCnt;
    logic [ACC_W-1:0]     nDisp;

    // Priority chain: clear > total > enter > number > digit; a higher
    // event consumes the cycle even when it has no effect in this state.
    always_comb begin
        nState   = state;
        nOperand = operand;
        nAcc     = acc;
        nCnt     = digit_cnt;
        if (keyRise[KEY_CLEAR]) begin
            nState   = ENTRY;
            nOperand = '0;
            nAcc     = '0;
            nCnt     = '0;
        end else if (state != ERROR) begin
            if (keyRise[KEY_TOTAL]) begin
                if (state == ENTRY) nState = SHOW;
            end else if (keyRise[KEY_ENTER]) begin
                if (sum <= SUM_W'(MAX_ACC)) begin
                    nAcc     = sum[ACC_W-1:0];
                    nOperand = '0;
                    nCnt     = '0;
                    nState   = ENTRY;
                end else begin
                    nState = ERROR;
                end
            end else if (keyRise[KEY_NUMBER]) begin
                if (state == SHOW) begin
                    nState   = ENTRY;
                    nOperand = '0;
                    nCnt     = '0;
                end
            end else if (digitValid) begin
                if (state == SHOW) begin
                    nOperand = OPERAND_W'(digitIdx);
                    nCnt     = CNT_W'(1);
                    nState   = ENTRY;
                end else if (digit_cnt < CNT_W'(MAX_DIGITS)) begin
                    nOperand = shifted;
                    nCnt     = digit_cnt + CNT_W'(1);
                end
            end
        end

        case (nState)
            ENTRY:   nDisp = ACC_W'(nOperand);
            SHOW:    nDisp = nAcc;
            default: nDisp = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ENTRY;
            operand    <= '0;
            acc        <= '0;
            digit_cnt  <= '0;
            disp_value <= '0;
            show       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= nState;
            operand    <= nOperand;
            acc        <= nAcc;
            digit_cnt  <= nCnt;
            disp_value <= nDisp;
            show       <= (nState == SHOW);
            err        <= (nState == ERROR);
        end
    end

endmodule
